// File: rtl/miss_classifier_pkg.sv
// Shared types for the miss classifier: recommendation codes, stat selectors,
// access classes and the per-access classification rule.
package miss_classifier_pkg;

  typedef enum logic [1:0] {
    REC_KEEP      = 2'd0,
    REC_INC_ASSOC = 2'd1,
    REC_INC_SIZE  = 2'd2,
    REC_RSVD      = 2'd3
  } rec_code_e;

  typedef enum logic [1:0] {
    STAT_HIT        = 2'd0,
    STAT_COMPULSORY = 2'd1,
    STAT_CAPACITY   = 2'd2,
    STAT_CONFLICT   = 2'd3
  } stat_sel_e;

  // Encoding matches stat_sel_e so the snapshot can be indexed by either.
  typedef enum logic [1:0] {
    CLS_HIT        = 2'd0,
    CLS_COMPULSORY = 2'd1,
    CLS_CAPACITY   = 2'd2,
    CLS_CONFLICT   = 2'd3
  } miss_class_e;

  typedef enum logic [1:0] {
    ST_COUNT  = 2'd0,
    ST_DECIDE = 2'd1,
    ST_REPORT = 2'd2
  } mc_state_e;

  function automatic miss_class_e classify_access(input logic real_hit,
                                                  input logic full_assoc_hit,
                                                  input logic full_assoc_full);
    miss_class_e cls;
    if (real_hit) begin
      cls = CLS_HIT;
    end else if (full_assoc_hit) begin
      cls = CLS_CONFLICT;
    end else if (full_assoc_full) begin
      cls = CLS_CAPACITY;
    end else begin
      cls = CLS_COMPULSORY;
    end
    return cls;
  endfunction

endpackage

// File: rtl/miss_classifier_chk.sv
// Elaboration-time parameter checks for miss_classifier.
module miss_classifier_chk #(
  parameter int CNT_W       = 16,
  parameter int WINDOW_LOG2 = 10
) ();

  // A full window must fit in a counter, otherwise class counts could wrap.
  if (WINDOW_LOG2 >= CNT_W) begin : g_bad_window
    $error("miss_classifier: WINDOW_LOG2 must be smaller than CNT_W");
  end

  if (WINDOW_LOG2 < 1) begin : g_tiny_window
    $error("miss_classifier: WINDOW_LOG2 must be at least 1");
  end

endmodule

// File: rtl/miss_classifier.sv
// Classifies cache accesses against a shadow fully-associative tracker, counts
// classes per window and issues a resize/reassociate recommendation.
module miss_classifier
  import miss_classifier_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int WINDOW_LOG2 = 10,
  parameter int CONF_SHIFT  = 1,
  parameter int CAP_SHIFT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             access_valid,
  input  logic             real_hit,
  input  logic             full_assoc_hit,
  input  logic             full_assoc_full,
  input  logic             cfg_clear,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [1:0]       rec_code,
  output logic             rec_overrun,
  input  logic [1:0]       stat_sel,
  output logic [CNT_W-1:0] stat_data
);

  localparam int ACC_W = WINDOW_LOG2 + 1;
  localparam int SUM_W = CNT_W + 2;
  localparam logic [ACC_W-1:0] LAST_ACC = ACC_W'((1 << WINDOW_LOG2) - 1);

  miss_classifier_chk #(.CNT_W(CNT_W), .WINDOW_LOG2(WINDOW_LOG2)) u_chk ();

  logic [CNT_W-1:0] live_r     [4];
  logic [CNT_W-1:0] live_nxt_s [4];
  logic [CNT_W-1:0] snap_r     [4];
  logic [ACC_W-1:0] access_cnt_r;
  logic [CNT_W-1:0] stat_data_r;
  logic [SUM_W-1:0] miss_sum_s;
  miss_class_e      cls_s;
  rec_code_e        dec_s;
  rec_code_e        rec_code_r;
  mc_state_e        state_r;
  logic             win_close_s;
  logic             rec_valid_r;
  logic             rec_overrun_r;

  // Classification, next live counts, window-close detect and the decision.
  always_comb begin
    cls_s       = classify_access(real_hit, full_assoc_hit, full_assoc_full);
    win_close_s = access_valid && (access_cnt_r == LAST_ACC);
    for (int i = 0; i < 4; i++) begin
      if (access_valid && (cls_s == miss_class_e'(i))) begin
        live_nxt_s[i] = live_r[i] + CNT_W'(1'b1);
      end else begin
        live_nxt_s[i] = live_r[i];
      end
    end
    miss_sum_s = SUM_W'(snap_r[CLS_COMPULSORY]) + SUM_W'(snap_r[CLS_CAPACITY])
               + SUM_W'(snap_r[CLS_CONFLICT]);
    // Conflict takes priority: adding ways is cheaper than growing the cache.
    if (miss_sum_s == '0) begin
      dec_s = REC_KEEP;
    end else if (SUM_W'(snap_r[CLS_CONFLICT]) > (miss_sum_s >> CONF_SHIFT)) begin
      dec_s = REC_INC_ASSOC;
    end else if (SUM_W'(snap_r[CLS_CAPACITY]) > (miss_sum_s >> CAP_SHIFT)) begin
      dec_s = REC_INC_SIZE;
    end else begin
      dec_s = REC_KEEP;
    end
  end

  // Live counters, window snapshot, decision FSM and sticky overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        live_r[i] <= '0;
        snap_r[i] <= '0;
      end
      access_cnt_r  <= '0;
      state_r       <= ST_COUNT;
      rec_code_r    <= REC_KEEP;
      rec_valid_r   <= 1'b0;
      rec_overrun_r <= 1'b0;
    end else if (cfg_clear) begin
      for (int i = 0; i < 4; i++) begin
        live_r[i] <= '0;
      end
      access_cnt_r  <= '0;
      state_r       <= ST_COUNT;
      rec_valid_r   <= 1'b0;
      rec_overrun_r <= 1'b0;
    end else begin
      if (win_close_s) begin
        for (int i = 0; i < 4; i++) begin
          live_r[i] <= '0;
        end
        access_cnt_r <= '0;
      end else begin
        live_r <= live_nxt_s;
        if (access_valid) begin
          access_cnt_r <= access_cnt_r + ACC_W'(1'b1);
        end
      end

      // A window closing outside COUNT is dropped; only the flag records it.
      if (win_close_s && (state_r != ST_COUNT)) begin
        rec_overrun_r <= 1'b1;
      end

      case (state_r)
        ST_COUNT: begin
          if (win_close_s) begin
            snap_r  <= live_nxt_s;
            state_r <= ST_DECIDE;
          end
        end
        ST_DECIDE: begin
          rec_code_r  <= dec_s;
          rec_valid_r <= 1'b1;
          state_r     <= ST_REPORT;
        end
        ST_REPORT: begin
          if (rec_ready) begin
            rec_valid_r <= 1'b0;
            state_r     <= ST_COUNT;
          end
        end
        default: begin
          rec_valid_r <= 1'b0;
          state_r     <= ST_COUNT;
        end
      endcase
    end
  end

  // Registered snapshot readback.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_data_r <= '0;
    end else begin
      stat_data_r <= snap_r[stat_sel];
    end
  end

  assign rec_valid   = rec_valid_r;
  assign rec_code    = rec_code_r;
  assign rec_overrun = rec_overrun_r;
  assign stat_data   = stat_data_r;

endmodule

// File: tb/tb_miss_classifier.sv
// Self-checking bench for miss_classifier with 16-access windows: table vectors,
// hand-written corner sequences and randomized windows against a count model.
module tb_miss_classifier;

  localparam int CNT_W = 16;
  localparam int WL    = 4;
  localparam int WIN   = 1 << WL;

  logic             clk = 1'b0;
  logic             rst, access_valid, real_hit, full_assoc_hit, full_assoc_full;
  logic             cfg_clear, rec_ready, rec_valid, rec_overrun;
  logic [1:0]       rec_code, stat_sel;
  logic [CNT_W-1:0] stat_data;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         nh, ncp, nca, ncf;
    logic [1:0] code;
    int         gaps;
  } vec_t;

  vec_t vt[8];

  always #5 clk = ~clk;

  miss_classifier #(.CNT_W(CNT_W), .WINDOW_LOG2(WL), .CONF_SHIFT(1), .CAP_SHIFT(1)) dut (
    .clk(clk), .rst(rst), .access_valid(access_valid), .real_hit(real_hit),
    .full_assoc_hit(full_assoc_hit), .full_assoc_full(full_assoc_full),
    .cfg_clear(cfg_clear), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_code(rec_code), .rec_overrun(rec_overrun), .stat_sel(stat_sel),
    .stat_data(stat_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Recommendation from window totals: a class dominates when it exceeds half the misses.
  function automatic logic [1:0] model_code(input int ncp, input int nca, input int ncf);
    int miss;
    miss = ncp + nca + ncf;
    if (miss == 0) return 2'd0;
    if (ncf > miss / 2) return 2'd1;
    if (nca > miss / 2) return 2'd2;
    return 2'd0;
  endfunction

  // Class 0 hit, 1 compulsory, 2 capacity, 3 conflict; don't-care inputs randomized.
  task automatic drive_class(input int c);
    case (c)
      0: begin real_hit = 1'b1; full_assoc_hit = 1'($urandom); full_assoc_full = 1'($urandom); end
      1: begin real_hit = 1'b0; full_assoc_hit = 1'b0; full_assoc_full = 1'b0; end
      2: begin real_hit = 1'b0; full_assoc_hit = 1'b0; full_assoc_full = 1'b1; end
      default: begin real_hit = 1'b0; full_assoc_hit = 1'b1; full_assoc_full = 1'($urandom); end
    endcase
  endtask

  // Applies a shuffled window; returns at the negedge after the closing edge.
  task automatic apply_window(input int nh, input int ncp, input int nca, input int ncf,
                              input int gaps, input bit clear_last);
    int cls[$];
    int tmp, j;
    repeat (nh)  cls.push_back(0);
    repeat (ncp) cls.push_back(1);
    repeat (nca) cls.push_back(2);
    repeat (ncf) cls.push_back(3);
    for (int i = cls.size() - 1; i > 0; i--) begin
      j = $urandom_range(i, 0);
      tmp = cls[i]; cls[i] = cls[j]; cls[j] = tmp;
    end
    for (int i = 0; i < cls.size(); i++) begin
      if (gaps > 0 && $urandom_range(2, 0) == 0) begin
        @(negedge clk);
        access_valid = 1'b0;
        drive_class($urandom_range(3, 0));
      end
      @(negedge clk);
      access_valid = 1'b1;
      drive_class(cls[i]);
      cfg_clear = (i == cls.size() - 1) ? clear_last : 1'b0;
    end
    @(negedge clk);
    access_valid = 1'b0;
    cfg_clear    = 1'b0;
  endtask

  task automatic read_stat(input string tag, input int sel, input int exp);
    stat_sel = 2'(sel);
    @(negedge clk);
    check($sformatf("%s_stat%0d", tag, sel), 32'(stat_data), 32'(exp));
  endtask

  task automatic check_report(input string tag, input logic [1:0] exp_code,
                              input int nh, input int ncp, input int nca, input int ncf,
                              input bit handshake);
    check({tag, "_valid_n1"}, 32'(rec_valid), 32'd0);
    @(negedge clk);
    check({tag, "_valid_n2"}, 32'(rec_valid), 32'd1);
    check({tag, "_code"}, 32'(rec_code), 32'(exp_code));
    read_stat(tag, 0, nh);
    read_stat(tag, 1, ncp);
    read_stat(tag, 2, nca);
    read_stat(tag, 3, ncf);
    check({tag, "_code_hold"}, 32'(rec_code), 32'(exp_code));
    if (handshake) begin
      rec_ready = 1'b1;
      @(negedge clk);
      rec_ready = 1'b0;
      check({tag, "_valid_drop"}, 32'(rec_valid), 32'd0);
    end
  endtask

  initial begin
    int cnt[4];
    int c;
    vt[0] = '{16, 0,  0,  0, 2'd0, 0};
    vt[1] = '{ 0, 6,  0, 10, 2'd1, 0};
    vt[2] = '{ 0, 0, 12,  4, 2'd2, 1};
    vt[3] = '{ 8, 4,  0,  4, 2'd0, 1};
    vt[4] = '{ 8, 0,  3,  5, 2'd1, 0};
    vt[5] = '{ 8, 0,  4,  4, 2'd0, 1};
    vt[6] = '{ 7, 0,  5,  4, 2'd2, 0};
    vt[7] = '{ 0, 16, 0,  0, 2'd0, 1};

    rst = 1'b1; access_valid = 1'b0; real_hit = 1'b0; full_assoc_hit = 1'b0;
    full_assoc_full = 1'b0; cfg_clear = 1'b0; rec_ready = 1'b0; stat_sel = 2'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_valid", 32'(rec_valid), 32'd0);
    check("rst_code", 32'(rec_code), 32'd0);
    check("rst_overrun", 32'(rec_overrun), 32'd0);
    check("rst_stat", 32'(stat_data), 32'd0);
    read_stat("rst", 3, 0);

    for (int v = 0; v < 8; v++) begin
      apply_window(vt[v].nh, vt[v].ncp, vt[v].nca, vt[v].ncf, vt[v].gaps, 1'b0);
      check_report($sformatf("vec%0d", v), vt[v].code, vt[v].nh, vt[v].ncp, vt[v].nca,
                   vt[v].ncf, 1'b1);
    end

    // Overrun: first report left pending while a second window closes.
    apply_window(16, 0, 0, 0, 0, 1'b0);
    check_report("ovr_a", 2'd0, 16, 0, 0, 0, 1'b0);
    check("ovr_a_flag", 32'(rec_overrun), 32'd0);
    apply_window(0, 0, 0, 16, 1, 1'b0);
    check("ovr_flag", 32'(rec_overrun), 32'd1);
    check("ovr_valid", 32'(rec_valid), 32'd1);
    check("ovr_code", 32'(rec_code), 32'd0);
    read_stat("ovr", 0, 16);
    read_stat("ovr", 3, 0);
    rec_ready = 1'b1;
    @(negedge clk);
    rec_ready = 1'b0;
    check("ovr_valid_drop", 32'(rec_valid), 32'd0);
    check("ovr_flag_sticky", 32'(rec_overrun), 32'd1);

    // cfg_clear coincident with the closing access: no report, snapshot kept.
    apply_window(0, 0, 0, 16, 0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("clr_no_valid%0d", i), 32'(rec_valid), 32'd0);
      @(negedge clk);
    end
    check("clr_overrun", 32'(rec_overrun), 32'd0);
    read_stat("clr", 0, 16);
    read_stat("clr", 3, 0);
    apply_window(16, 0, 0, 0, 0, 1'b0);
    check_report("clr_next", 2'd0, 16, 0, 0, 0, 1'b1);

    // Synchronous reset while a report is pending drops it.
    apply_window(0, 0, 0, 16, 0, 1'b0);
    check_report("prerst", 2'd1, 0, 0, 0, 16, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_valid", 32'(rec_valid), 32'd0);
    check("midrst_code", 32'(rec_code), 32'd0);
    check("midrst_stat", 32'(stat_data), 32'd0);
    apply_window(16, 0, 0, 0, 0, 1'b0);
    check_report("postrst", 2'd0, 16, 0, 0, 0, 1'b1);

    // Randomized windows checked against the count model.
    for (int w = 0; w < 12; w++) begin
      for (int k = 0; k < 4; k++) cnt[k] = 0;
      for (int a = 0; a < WIN; a++) begin
        c = (w % 3 == 0) ? $urandom_range(3, 0) : $urandom_range(3, 1);
        cnt[c]++;
      end
      apply_window(cnt[0], cnt[1], cnt[2], cnt[3], 1, 1'b0);
      check_report($sformatf("rnd%0d", w), model_code(cnt[1], cnt[2], cnt[3]),
                   cnt[0], cnt[1], cnt[2], cnt[3], 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
